// File: rtl/anode_scanner.sv
// Seven-segment anode scanner: walks digits 0..3, each preceded by an all-off blanking gap,
// and drives the active-low anode pattern and the slot index that the segment decoder consumes.
module anode_scanner #(
    parameter int DIV_COUNT    = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [3:0] digit_mask,
    output logic [3:0] anode,
    output logic [1:0] digit_idx,
    output logic       frame_tick
);

    localparam int MAX_COUNT = (DIV_COUNT > BLANK_CYCLES) ? DIV_COUNT : BLANK_CYCLES;
    localparam int CNT_W     = $clog2(MAX_COUNT) + 1;

    localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(DIV_COUNT - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [3:0]       ANODE_OFF  = 4'b1111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        DRIVE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       digit_idx_q, digit_idx_d;
    logic [3:0]       anode_q, anode_d;
    logic             frame_tick_q, frame_tick_d;

    // A masked-off digit keeps its time slot but leaves every anode high.
    function automatic logic [3:0] drive_pattern(input logic [1:0] idx, input logic [3:0] mask);
        return ~(4'b0001 << idx) | ~{4{mask[idx]}};
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            digit_idx_q  <= 2'd0;
            anode_q      <= ANODE_OFF;
            frame_tick_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            digit_idx_q  <= digit_idx_d;
            anode_q      <= anode_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    // Outputs are computed for the state being entered, so they register with no extra latency.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        digit_idx_d  = digit_idx_q;
        anode_d      = ANODE_OFF;
        frame_tick_d = 1'b0;

        if (!enable) begin
            state_d     = IDLE;
            cnt_d       = '0;
            digit_idx_d = 2'd0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d     = BLANK;
                    cnt_d       = '0;
                    digit_idx_d = 2'd0;
                end
                BLANK: begin
                    if (cnt_q == BLANK_LAST) begin
                        state_d = DRIVE;
                        cnt_d   = '0;
                        anode_d = drive_pattern(digit_idx_q, digit_mask);
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                DRIVE: begin
                    if (cnt_q == DRIVE_LAST) begin
                        state_d      = BLANK;
                        cnt_d        = '0;
                        digit_idx_d  = digit_idx_q + 2'd1;
                        frame_tick_d = (digit_idx_q == 2'd3);
                    end else begin
                        cnt_d   = cnt_q + CNT_W'(1);
                        anode_d = drive_pattern(digit_idx_q, digit_mask);
                    end
                end
                default: begin
                    state_d     = IDLE;
                    cnt_d       = '0;
                    digit_idx_d = 2'd0;
                end
            endcase
        end
    end

    assign anode      = anode_q;
    assign digit_idx  = digit_idx_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_anode_scanner.sv
// Directed bench for anode_scanner with DIV_COUNT=4, BLANK_CYCLES=2 (24-cycle frame).
module tb_anode_scanner;

    logic       clk;
    logic       reset;
    logic       enable;
    logic [3:0] digit_mask;
    logic [3:0] anode;
    logic [1:0] digit_idx;
    logic       frame_tick;

    int pass_cnt = 0;
    int total_cnt = 0;

    anode_scanner #(
        .DIV_COUNT   (4),
        .BLANK_CYCLES(2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .digit_mask(digit_mask),
        .anode     (anode),
        .digit_idx (digit_idx),
        .frame_tick(frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expects the DUT in IDLE with enable already high; the first edge inside starts the scan.
    task automatic run_seq(input logic [3:0] mask, input int ncyc, input string name);
        int         pos;
        int         d;
        logic [3:0] exp_anode;
        logic [1:0] exp_idx;
        logic       exp_tick;
        logic [3:0] onehot;
        for (int k = 0; k < ncyc; k++) begin
            @(posedge clk); #1;
            pos       = k % 24;
            d         = pos / 6;
            exp_idx   = 2'(d);
            onehot    = 4'b0001 << d;
            exp_anode = ((pos % 6) < 2 || !mask[d]) ? 4'b1111 : ~onehot;
            exp_tick  = (pos == 0) && (k > 0);
            total_cnt++;
            if (anode !== exp_anode)
                $display("FAIL %s anode cycle %0d: got %b expected %b", name, k, anode, exp_anode);
            else pass_cnt++;
            total_cnt++;
            if (digit_idx !== exp_idx)
                $display("FAIL %s digit_idx cycle %0d: got %0d expected %0d", name, k, digit_idx, exp_idx);
            else pass_cnt++;
            total_cnt++;
            if (frame_tick !== exp_tick)
                $display("FAIL %s frame_tick cycle %0d: got %b expected %b", name, k, frame_tick, exp_tick);
            else pass_cnt++;
        end
    endtask

    task automatic go_idle_then_enable(input logic [3:0] mask);
        enable = 1'b0;
        @(posedge clk); #1;
        digit_mask = mask;
        enable     = 1'b1;
    endtask

    task automatic test_reset;
        reset      = 1'b1;
        enable     = 1'b0;
        digit_mask = 4'b1111;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            total_cnt++;
            if (anode !== 4'b1111 || digit_idx !== 2'd0 || frame_tick !== 1'b0)
                $display("FAIL reset_idle cycle %0d: got anode=%b idx=%0d tick=%b expected 1111/0/0",
                         k, anode, digit_idx, frame_tick);
            else pass_cnt++;
        end
    endtask

    task automatic test_scan_full;
        go_idle_then_enable(4'b1111);
        run_seq(4'b1111, 49, "scan_full");
    endtask

    task automatic test_mask;
        go_idle_then_enable(4'b1010);
        run_seq(4'b1010, 49, "mask_1010");
    endtask

    task automatic test_disable_restart;
        go_idle_then_enable(4'b1111);
        run_seq(4'b1111, 14, "pre_disable");
        enable = 1'b0;
        @(posedge clk); #1;
        total_cnt++;
        if (anode !== 4'b1111 || digit_idx !== 2'd0 || frame_tick !== 1'b0)
            $display("FAIL disable_mid_dig2: got anode=%b idx=%0d tick=%b expected 1111/0/0",
                     anode, digit_idx, frame_tick);
        else pass_cnt++;
        enable = 1'b1;
        run_seq(4'b1111, 12, "restart");
    endtask

    task automatic test_async_reset;
        go_idle_then_enable(4'b1111);
        run_seq(4'b1111, 9, "pre_reset");
        #2;
        reset = 1'b1;
        #1;
        total_cnt++;
        if (anode !== 4'b1111 || digit_idx !== 2'd0 || frame_tick !== 1'b0)
            $display("FAIL async_reset: got anode=%b idx=%0d tick=%b expected 1111/0/0",
                     anode, digit_idx, frame_tick);
        else pass_cnt++;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_random;
        logic prev_tick = 1'b0;
        logic en_edge;
        for (int k = 0; k < 1000; k++) begin
            enable     = ($urandom_range(0, 15) != 0);
            digit_mask = 4'($urandom_range(0, 15));
            en_edge    = enable;
            @(posedge clk); #1;
            total_cnt++;
            if ($countones(~anode) > 1)
                $display("FAIL rand_onehot cycle %0d: got anode=%b expected 1111 or one zero", k, anode);
            else pass_cnt++;
            total_cnt++;
            if (frame_tick && (prev_tick || !en_edge || digit_idx !== 2'd0 || anode !== 4'b1111))
                $display("FAIL rand_tick cycle %0d: got tick=%b prev=%b en=%b idx=%0d anode=%b expected legal tick",
                         k, frame_tick, prev_tick, en_edge, digit_idx, anode);
            else pass_cnt++;
            prev_tick = frame_tick;
        end
    endtask

    initial begin
        test_reset();
        test_scan_full();
        test_mask();
        test_disable_restart();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
